fold_reduce_40: RTL and testbench
=================================

Name: fold_reduce_40

Overview:
- Sequential overflow-fold reducer for the 40x40 modular datapath.
- Takes a 44-bit value: a 40-bit residue plus a 4-bit overflow nibble M, as produced by the adder tree.
- Repeatedly turns the overflow nibble into a 40-bit correction constant, adds it to the low 40 bits, and re-checks until the overflow nibble is zero.
- This is the producer/consumer of the correction digit: it generates M, looks up the correction, and retires it. It sits between the accumulation stage and the downstream modular adder, with valid/ready on both sides.

Parameters:
- W, 40: residue width (fixed at 40; the correction table is defined only for 40).
- MAX_ITER, 2: fold-iteration cap before the error flag; 2 is the proven worst case.
- ITW, 2: width of the iteration counter and out_iters; must hold MAX_ITER.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_data  in  44  {M[3:0], residue[39:0]}
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  40  reduced residue
- out_iters  out  ITW  number of folds applied
- out_err  out  1  cap reached with a nonzero overflow nibble
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, acc=0, iter=0.
  - out_valid=0, out_data=0, out_iters=0, out_err=0, busy=0.
  - in_ready=1 one delta after rst deasserts.
- Reset mid-operation aborts immediately. The word in flight is dropped and no output is produced.
- Correction function corr(M), 40 bits:
  - corr(0)=0.
  - corr(k)=0x8000000000 − (k−1)·0x05BFC65FEF for k=1..15.
  - Sample values: corr(1)=0x8000000000, corr(2)=0x7A4039A011, corr(15)=0x2F8326C0EE.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, load acc←in_data (44 b), iter←0, go to FOLD.
  - FOLD: in_ready=0. Let M=acc[43:40].
    - If M==0: register out_data←acc[39:0], out_iters←iter, out_err←0; go to OUT.
    - Else if iter==MAX_ITER: out_data←acc[39:0], out_iters←iter, out_err←1; go to OUT.
    - Else: acc←{4'b0,acc[39:0]} + {4'b0,corr(M)} (44-bit add, carry lands in acc[43:40]); iter←iter+1; stay in FOLD.
  - OUT: out_valid=1. out_data, out_iters and out_err are held stable until out_ready is sampled high; then go to IDLE.
- Latency: with k folds and the accept in cycle 0, out_valid rises in cycle k+2. Steady throughput is one word per k+3 cycles (no overlap).
- Arithmetic bound: the carry after any fold is ≤1.
  - Any M≥2 gives low' < 2^39, so the next fold, with M=1, leaves acc[43:40]=0.
  - An initial M=1 with low≥2^39 needs exactly 2 folds.
  - Hence k≤2, and out_err never fires with MAX_ITER≥2.
- in_valid while not in IDLE is ignored. The source must hold the word until in_ready.
- out_ready high in the same cycle out_valid first rises is accepted; the block returns to IDLE next cycle.
- If out_ready is held low, OUT stalls indefinitely with no data change.

Decomposition:
- Shared package fold40_pkg holds:
  - constants CORR_BASE=40'h8000000000 and CORR_STEP=40'h05BFC65FEF;
  - the 16-entry CORR_TBL as a localparam array;
  - the state enum {IDLE, FOLD, OUT};
  - OVF_W=4.
- One natural sub-module: fold40_corr_rom, combinational, M[3:0] → corr[39:0], implemented from CORR_TBL. Everything else stays in the top level.

Test Plan:
- in_data=0x0_1234567890 → out_data=0x1234567890, out_iters=0, out_err=0, out_valid in cycle 2.
- in_data=0x1_0000000000 → out_data=0x8000000000, out_iters=1, out_valid in cycle 3.
- in_data=0x2_FFFFFFFFFF → fold 1 gives acc=0x17A4039A010, fold 2 gives out_data=0xFA4039A010, out_iters=2, out_valid in cycle 4.
- in_data=0xF_FFFFFFFFFF → out_data=0xAF8326C0ED, out_iters=2; in_ready stays 0 until the output handshake completes.
- With MAX_ITER=1, in_data=0x1_FFFFFFFFFF → out_err=1, out_data=0x7FFFFFFFFF, out_iters=1.
- Back-pressure then reset:
  - hold out_ready=0 for 5 cycles → out_data stable, in_ready=0;
  - assert rst mid-FOLD on a fresh word → out_valid=0 and in_ready=1 right after deassert, and no stale output appears.

Source files
------------

// File: rtl/fold40_pkg.sv
// fold40_pkg: shared definitions for the 40-bit overflow-fold reducer.
//   OVF_W     - width of the overflow nibble M sitting above the residue
//   CORR_BASE - correction for M=1 (2^39)
//   CORR_STEP - amount the correction drops for each further unit of M
//   CORR_TBL  - corr(M) for M=0..15, corr(k) = CORR_BASE - (k-1)*CORR_STEP
//   state_e   - reducer control states
package fold40_pkg;

  localparam int OVF_W = 4;

  localparam logic [39:0] CORR_BASE = 40'h80_0000_0000;
  localparam logic [39:0] CORR_STEP = 40'h05_BFC6_5FEF;

  localparam logic [39:0] CORR_TBL [16] = '{
    40'h0,
    CORR_BASE,
    CORR_BASE - 40'd1  * CORR_STEP,
    CORR_BASE - 40'd2  * CORR_STEP,
    CORR_BASE - 40'd3  * CORR_STEP,
    CORR_BASE - 40'd4  * CORR_STEP,
    CORR_BASE - 40'd5  * CORR_STEP,
    CORR_BASE - 40'd6  * CORR_STEP,
    CORR_BASE - 40'd7  * CORR_STEP,
    CORR_BASE - 40'd8  * CORR_STEP,
    CORR_BASE - 40'd9  * CORR_STEP,
    CORR_BASE - 40'd10 * CORR_STEP,
    CORR_BASE - 40'd11 * CORR_STEP,
    CORR_BASE - 40'd12 * CORR_STEP,
    CORR_BASE - 40'd13 * CORR_STEP,
    CORR_BASE - 40'd14 * CORR_STEP
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/fold40_corr_rom.sv
// fold40_corr_rom: combinational lookup of the 40-bit correction constant.
//   m    in  OVF_W  overflow nibble
//   corr out 40     corr(m), zero for m=0
module fold40_corr_rom
  import fold40_pkg::*;
(
  input  logic [OVF_W-1:0] m,
  output logic [39:0]      corr
);

  assign corr = CORR_TBL[m];

endmodule

// File: rtl/fold_reduce_40.sv
// fold_reduce_40: sequential overflow-fold reducer. Takes {M, residue}, folds
// corr(M) into the residue until the overflow nibble clears (or the iteration
// cap is hit) and presents the reduced residue with valid/ready.
//   clk, rst             clock, async active-high reset
//   in_valid/in_ready    input handshake, in_data = {M[3:0], residue[39:0]}
//   out_valid/out_ready  output handshake
//   out_data             reduced residue
//   out_iters            folds applied
//   out_err              cap reached with a nonzero overflow nibble
//   busy                 high whenever not IDLE
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// FOLD  | one fold per cycle until M==0 or the cap; result registered on exit
// OUT   | result presented, held until out_ready
module fold_reduce_40
  import fold40_pkg::*;
#(
  parameter int W        = 40,
  parameter int MAX_ITER = 2,
  parameter int ITW      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W+OVF_W-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [ITW-1:0]       out_iters,
  output logic                 out_err,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic [W+OVF_W-1:0]   acc_q, acc_d;
  logic [ITW-1:0]       iter_q, iter_d;
  logic [W-1:0]         out_data_q, out_data_d;
  logic [ITW-1:0]       out_iters_q, out_iters_d;
  logic                 out_err_q, out_err_d;

  logic [OVF_W-1:0]     ovf;
  logic [W-1:0]         corr;
  logic                 ovf_zero;
  logic                 at_cap;

  assign ovf      = acc_q[W+OVF_W-1:W];
  assign ovf_zero = (ovf == '0);
  assign at_cap   = (iter_q == ITW'(MAX_ITER));

  fold40_corr_rom u_corr_rom (
    .m    (ovf),
    .corr (corr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      iter_q      <= '0;
      out_data_q  <= '0;
      out_iters_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      iter_q      <= iter_d;
      out_data_q  <= out_data_d;
      out_iters_q <= out_iters_d;
      out_err_q   <= out_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)               state_d = FOLD;
      FOLD:    if (ovf_zero || at_cap)     state_d = OUT;
      OUT:     if (out_ready)              state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Datapath: the fold keeps the residue and adds corr(M); any carry lands in
  // the overflow nibble and is re-examined on the next FOLD cycle.
  always_comb begin
    acc_d       = acc_q;
    iter_d      = iter_q;
    out_data_d  = out_data_q;
    out_iters_d = out_iters_q;
    out_err_d   = out_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d  = in_data;
          iter_d = '0;
        end
      end
      FOLD: begin
        if (ovf_zero || at_cap) begin
          out_data_d  = acc_q[W-1:0];
          out_iters_d = iter_q;
          out_err_d   = !ovf_zero;
        end else begin
          acc_d  = {{OVF_W{1'b0}}, acc_q[W-1:0]} + {{OVF_W{1'b0}}, corr};
          iter_d = iter_q + ITW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
  end

  assign out_data  = out_data_q;
  assign out_iters = out_iters_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_fold_reduce_40.sv
module tb_fold_reduce_40;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // main instance (MAX_ITER=2)
  logic        in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [43:0] in_data;
  logic [39:0] out_data;
  logic [1:0]  out_iters;

  // capped instance (MAX_ITER=1) to reach the error path
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err, c_busy;
  logic [43:0] c_in_data;
  logic [39:0] c_out_data;
  logic [1:0]  c_out_iters;

  fold_reduce_40 #(.W(40), .MAX_ITER(2), .ITW(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_iters(out_iters), .out_err(out_err), .busy(busy)
  );

  fold_reduce_40 #(.W(40), .MAX_ITER(1), .ITW(2)) dut_cap (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_iters(c_out_iters), .out_err(c_out_err), .busy(c_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [39:0] data;
    logic [1:0]  iters;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // corr(M) straight from the closed form, in 64-bit integer arithmetic
  function automatic longint unsigned corr_ref(input longint unsigned m);
    if (m == 0) return 0;
    return 64'h80_0000_0000 - (m - 1) * 64'h05_BFC6_5FEF;
  endfunction

  // Reference: value = M*2^40 + low; each fold replaces it with low + corr(M)
  function automatic exp_t model(input logic [43:0] d, input int cap);
    exp_t e;
    longint unsigned v;
    longint unsigned two40;
    int folds;
    two40 = 64'h100_0000_0000;
    v = 64'(d);
    folds = 0;
    e.err = 1'b0;
    for (int g = 0; g < 16; g++) begin
      if (v / two40 == 0) break;
      if (folds == cap) begin
        e.err = 1'b1;
        break;
      end
      v = (v % two40) + corr_ref(v / two40);
      folds++;
    end
    e.data    = 40'(v % two40);
    e.iters   = 2'(folds);
    e.lat     = folds + 2;
    e.acc_cyc = 0;
    return e;
  endfunction

  // Presents a word to the main DUT and holds it until accepted. Returns at
  // the falling edge following the accepting rising edge.
  task automatic send(input logic [43:0] d, input bit push, output bit ok);
    exp_t e;
    int t;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      timeout_fail("send_wait_in_ready");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    ok = 1'b1;
    if (push) begin
      e = model(d, 2);
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic send_cap(input logic [43:0] d, input string name);
    exp_t e;
    int t;
    e = model(d, 1);
    @(negedge clk);
    c_in_valid = 1'b1;
    c_in_data  = d;
    t = 0;
    while (!c_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!c_in_ready) begin
      timeout_fail({name, "_in_ready"});
      c_in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    c_in_valid = 1'b0;
    t = 0;
    while (!c_out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!c_out_valid) begin
      timeout_fail({name, "_out_valid"});
      return;
    end
    check({name, "_data"},  64'(c_out_data),  64'(e.data));
    check({name, "_iters"}, 64'(c_out_iters), 64'(e.iters));
    check({name, "_err"},   64'(c_out_err),   64'(e.err));
    @(negedge clk);
  endtask

  // Scoreboard monitor for the main DUT
  initial begin
    bit          seen;
    exp_t        e;
    logic [39:0] hold_data;
    logic [1:0]  hold_iters;
    logic        hold_err;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (out_valid) begin
          check("in_ready_low_in_out", 64'(in_ready), 64'd0);
          check("busy_in_out", 64'(busy), 64'd1);
          if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_output: got %0h, expected no output", out_data);
              hold_data  = out_data;
              hold_iters = out_iters;
              hold_err   = out_err;
            end else begin
              e = sb.pop_front();
              check("out_data",  64'(out_data),  64'(e.data));
              check("out_iters", 64'(out_iters), 64'(e.iters));
              check("out_err",   64'(out_err),   64'(e.err));
              check("latency",   64'(cyc - e.acc_cyc + 1), 64'(e.lat));
              hold_data  = e.data;
              hold_iters = e.iters;
              hold_err   = e.err;
            end
          end else begin
            check("stall_data",  64'(out_data),  64'(hold_data));
            check("stall_iters", 64'(out_iters), 64'(hold_iters));
            check("stall_err",   64'(out_err),   64'(hold_err));
          end
        end
        out_ready = ($urandom_range(0, 2) != 0);
        if (out_valid && out_ready) seen = 1'b0;
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    logic [43:0] dir_words [4];
    logic [43:0] d;
    bit ok;
    int t;

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    c_in_valid  = 1'b0;
    c_in_data   = '0;
    c_out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_iters", 64'(out_iters), 64'd0);
    check("rst_out_err",   64'(out_err),   64'd0);

    // directed words, then random ones, all through the scoreboard
    mon_en = 1'b1;
    dir_words[0] = 44'h0_12_3456_7890;
    dir_words[1] = 44'h1_00_0000_0000;
    dir_words[2] = 44'h2_FF_FFFF_FFFF;
    dir_words[3] = 44'hF_FF_FFFF_FFFF;
    for (int i = 0; i < 4; i++) send(dir_words[i], 1'b1, ok);
    for (int i = 0; i < 150; i++) begin
      d = {4'($urandom_range(0, 15)), 8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) d[43:39] = 5'b00011;
      send(d, 1'b1, ok);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || out_valid) timeout_fail("drain_scoreboard");
    mon_en = 1'b0;

    // capped instance: error path and a few random words
    send_cap(44'h1_FF_FFFF_FFFF, "cap_err");
    send_cap(44'h1_00_0000_0001, "cap_one");
    for (int i = 0; i < 6; i++) begin
      d = {4'($urandom_range(0, 15)), 8'($urandom), 32'($urandom)};
      send_cap(d, "cap_rand");
    end

    // back-pressure: out_ready low for 5 cycles, result must hold
    @(negedge clk);
    out_ready = 1'b0;
    send(44'h1_00_0000_0000, 1'b0, ok);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) timeout_fail("bp_out_valid");
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_data",  64'(out_data),  64'h80_0000_0000);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_released", 64'(in_ready), 64'd1);

    // reset while folding a fresh word: nothing may come out
    send(44'h2_FF_FFFF_FFFF, 1'b0, ok);
    check("mid_fold_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy",      64'(busy),      64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready",  64'(in_ready),  64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_output", 64'(out_valid), 64'd0);
    end

    // block still works after the abort
    mon_en = 1'b1;
    send(44'hF_FF_FFFF_FFFF, 1'b1, ok);
    send(44'h0_12_3456_7890, 1'b1, ok);
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || out_valid) timeout_fail("drain_after_reset");
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
